// File: rtl/demux_1x2_reg.sv
// Registered 1-to-2 stream distributor: steers one valid/ready input to the low branch,
// the high branch, both or neither. Each branch has a one-entry output register.
module demux_1x2_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int COMMMAND_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [DATA_WIDTH-1:0]     i_data_bus,
   input  logic                      i_en,
   input  logic [COMMMAND_WIDTH-1:0] i_cmd,
   output logic [1:0]                o_valid,
   output logic [2*DATA_WIDTH-1:0]   o_data_bus,
   input  logic [1:0]                i_ready
);

   logic [1:0]            vld_p1;
   logic [DATA_WIDTH-1:0] data_p1 [2];
   logic [1:0]            tgt;
   logic [1:0]            can_acc;
   logic [1:0]            load;
   logic [1:0]            pop;
   logic                  fire_in;

   // Multicast is all-or-nothing: every targeted branch must be able to accept.
   always_comb begin
      tgt     = i_cmd[1:0];
      can_acc = ~vld_p1 | i_ready;
      o_ready = i_en && !rst && ((tgt & ~can_acc) == 2'b00);
      fire_in = i_valid && o_ready;
      load    = fire_in ? tgt : 2'b00;
      pop     = vld_p1 & i_ready;
   end

   // Stage p1: per-branch output slot; a popped slot without a new load clears to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1     <= 2'b00;
         data_p1[0] <= '0;
         data_p1[1] <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (load[b]) begin
               vld_p1[b]  <= 1'b1;
               data_p1[b] <= i_data_bus;
            end else if (pop[b]) begin
               vld_p1[b]  <= 1'b0;
               data_p1[b] <= '0;
            end
         end
      end
   end

   assign o_valid    = vld_p1;
   assign o_data_bus = {data_p1[1], data_p1[0]};

endmodule

// File: tb/tb_demux_1x2_reg.sv
// Directed bench for demux_1x2_reg: queue-based branch model checked every cycle,
// plus hand-computed literal expectations from the test plan.
module tb_demux_1x2_reg;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid;
   logic          o_ready;
   logic [DW-1:0] i_data_bus;
   logic          i_en;
   logic [1:0]    i_cmd;
   logic [1:0]    o_valid;
   logic [2*DW-1:0] o_data_bus;
   logic [1:0]    i_ready;

   int checks = 0;
   int errors = 0;
   bit model_on = 1'b0;

   // Model: each branch is a queue of at most one word
   logic [DW-1:0] q_lo[$];
   logic [DW-1:0] q_hi[$];

   demux_1x2_reg #(.DATA_WIDTH(DW), .COMMMAND_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_data_bus(i_data_bus), .i_en(i_en), .i_cmd(i_cmd),
      .o_valid(o_valid), .o_data_bus(o_data_bus), .i_ready(i_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_ready();
      bit lo_blocked, hi_blocked;
      lo_blocked = i_cmd[0] && (q_lo.size() != 0) && !i_ready[0];
      hi_blocked = i_cmd[1] && (q_hi.size() != 0) && !i_ready[1];
      return i_en && !rst && !lo_blocked && !hi_blocked;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q_lo.delete();
         q_hi.delete();
      end else begin
         bit fire;
         fire = i_valid && model_ready();
         if (q_lo.size() != 0 && i_ready[0]) void'(q_lo.pop_front());
         if (q_hi.size() != 0 && i_ready[1]) void'(q_hi.pop_front());
         if (fire && i_cmd[0]) q_lo.push_back(i_data_bus);
         if (fire && i_cmd[1]) q_hi.push_back(i_data_bus);
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         logic [1:0]    ev;
         logic [DW-1:0] elo, ehi;
         ev  = {q_hi.size() != 0, q_lo.size() != 0};
         elo = (q_lo.size() != 0) ? q_lo[0] : '0;
         ehi = (q_hi.size() != 0) ? q_hi[0] : '0;
         chk("model_o_valid", {62'd0, o_valid}, {62'd0, ev});
         chk("model_o_data", o_data_bus, {ehi, elo});
         chk("model_o_ready", {63'd0, o_ready}, {63'd0, model_ready()});
      end
   end

   // Apply inputs just after a rising edge, then wait to the falling edge for checks
   task automatic drive(input logic r, input logic v, input logic en, input logic [1:0] cmd,
                        input logic [DW-1:0] d, input logic [1:0] rdy);
      rst = r; i_valid = v; i_en = en; i_cmd = cmd; i_data_bus = d; i_ready = rdy;
      @(negedge clk);
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; i_valid = 1'b1; i_en = 1'b1; i_cmd = 2'b11; i_data_bus = 32'hDEADBEEF; i_ready = 2'b11;
      next();
      model_on = 1'b1;

      // Reset held for two cycles with an active input
      drive(1, 1, 1, 2'b11, 32'hDEADBEEF, 2'b11);
      chk("rst_o_valid", {62'd0, o_valid}, 64'd0);
      chk("rst_o_data", o_data_bus, 64'd0);
      chk("rst_o_ready", {63'd0, o_ready}, 64'd0);
      next();
      drive(0, 0, 1, 2'b11, 32'h0, 2'b11);
      chk("post_rst_o_ready", {63'd0, o_ready}, 64'd1);
      next();

      // Unicast low then high
      drive(0, 1, 1, 2'b01, 32'hAAAAAAAA, 2'b11);
      next();
      drive(0, 1, 1, 2'b10, 32'hFFFFFFFF, 2'b11);
      chk("uni_c1_valid", {62'd0, o_valid}, 64'd1);
      chk("uni_c1_low", {32'd0, o_data_bus[31:0]}, 64'h00000000AAAAAAAA);
      next();
      drive(0, 0, 1, 2'b00, 32'h0, 2'b11);
      chk("uni_c2_valid", {62'd0, o_valid}, 64'd2);
      chk("uni_c2_data", o_data_bus, 64'hFFFFFFFF_00000000);
      next();
      drive(0, 0, 1, 2'b00, 32'h0, 2'b11);
      chk("uni_drain", {62'd0, o_valid}, 64'd0);
      next();

      // Multicast with backpressure on the high branch
      drive(0, 1, 1, 2'b11, 32'h12345678, 2'b11);
      next();
      drive(0, 1, 1, 2'b11, 32'h0, 2'b01);
      chk("mc_c1_valid", {62'd0, o_valid}, 64'd3);
      chk("mc_c1_data", o_data_bus, 64'h12345678_12345678);
      chk("mc_c1_ready", {63'd0, o_ready}, 64'd0);
      next();
      drive(0, 1, 1, 2'b11, 32'h0, 2'b01);
      chk("mc_c2_valid", {62'd0, o_valid}, 64'd2);
      chk("mc_c2_data", o_data_bus, 64'h12345678_00000000);
      chk("mc_c2_ready", {63'd0, o_ready}, 64'd0);
      next();
      drive(0, 0, 1, 2'b11, 32'h0, 2'b11);
      next();
      drive(0, 0, 1, 2'b00, 32'h0, 2'b11);
      chk("mc_drain", {62'd0, o_valid}, 64'd0);
      next();

      // Disable, then drop
      drive(0, 1, 0, 2'b01, 32'h11111111, 2'b11);
      chk("dis_ready", {63'd0, o_ready}, 64'd0);
      next();
      drive(0, 1, 1, 2'b00, 32'h22222222, 2'b11);
      chk("dis_valid", {62'd0, o_valid}, 64'd0);
      chk("drop_ready", {63'd0, o_ready}, 64'd1);
      next();
      drive(0, 0, 1, 2'b00, 32'h0, 2'b11);
      chk("drop_valid", {62'd0, o_valid}, 64'd0);
      chk("drop_data", o_data_bus, 64'd0);
      next();

      // Streaming with simultaneous pop and load on the low branch
      for (int k = 1; k <= 4; k++) begin
         drive(0, 1, 1, 2'b01, k, 2'b01);
         chk("stream_ready", {63'd0, o_ready}, 64'd1);
         if (k > 1) begin
            chk("stream_valid", {62'd0, o_valid}, 64'd1);
            chk("stream_low", {32'd0, o_data_bus[31:0]}, 64'(k - 1));
         end
         next();
      end
      drive(0, 0, 1, 2'b01, 32'h0, 2'b01);
      chk("stream_last", o_data_bus, 64'd4);
      next();

      // Reset with both slots full and stalled
      drive(0, 1, 1, 2'b11, 32'h55555555, 2'b00);
      next();
      drive(0, 0, 1, 2'b11, 32'h0, 2'b00);
      chk("mid_full", {62'd0, o_valid}, 64'd3);
      next();
      drive(1, 0, 1, 2'b11, 32'h0, 2'b00);
      chk("mid_rst_ready", {63'd0, o_ready}, 64'd0);
      next();
      drive(0, 0, 1, 2'b11, 32'h0, 2'b00);
      chk("mid_valid", {62'd0, o_valid}, 64'd0);
      chk("mid_data", o_data_bus, 64'd0);
      chk("mid_ready", {63'd0, o_ready}, 64'd1);
      next();

      // Mixed traffic, checked by the model alone
      for (int n = 0; n < 200; n++) begin
         drive(1'($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom_range(0, 7) != 0),
               2'($urandom), $urandom, 2'($urandom));
         next();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux_1x2_reg.md
Name: demux_1x2_reg

Overview:
- Registered 1-to-2 distributor: the inverse of the 2:1 branch mux in the NoC switch fabric.
- One input stream is steered to the low branch, the high branch, both (multicast) or neither (drop), according to i_cmd.
- Each branch has a one-entry output register with valid/ready backpressure.
- Sits at switch/tree fan-out points where one upstream link feeds two downstream links.

Parameters:
- DATA_WIDTH, 32, payload width per branch; data format is passed through unchanged.
- COMMMAND_WIDTH, 2, command width; fixed at 2; other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- i_valid  input  1  upstream data valid.
- o_ready  output  1  upstream may transfer this cycle (combinational).
- i_data_bus  input  DATA_WIDTH  upstream payload.
- i_en  input  1  demux enable.
- i_cmd  input  COMMMAND_WIDTH  routing command: 00 drop, 01 low branch, 10 high branch, 11 both.
- o_valid  output  2  per-branch valid; bit0 = low branch, bit1 = high branch.
- o_data_bus  output  2*DATA_WIDTH  [DATA_WIDTH-1:0] = low branch, [DATA_WIDTH+:DATA_WIDTH] = high branch.
- i_ready  input  2  per-branch downstream ready; bit0 = low, bit1 = high.

Behaviour:
- Reset:
  - On a clk edge with rst=1: o_valid=2'b00 and o_data_bus all zeros, regardless of other inputs.
  - o_ready=0 while rst=1.
  - Reset mid-transfer discards all held data; no output handshake completes in that cycle.
- Per-branch state: slot b is EMPTY (o_valid[b]=0) or FULL (o_valid[b]=1). No further FSM.
- Branch can-accept: can_acc[b] = !o_valid[b] || i_ready[b].
- Upstream ready:
  - o_ready = i_en && !rst && (every branch targeted by i_cmd has can_acc=1).
  - cmd 00 targets no branch, so o_ready = i_en.
  - cmd 11 requires both branches to be able to accept. Multicast is all-or-nothing: never write one branch and stall the other.
- Input transfer: fire_in = i_valid && o_ready. On fire_in, every targeted slot loads i_data_bus and sets o_valid[b]=1 at the next edge.
  - Latency: 1 cycle, input to output.
  - Throughput: 1 transfer/cycle per branch under continuous i_ready.
- Output transfer: pop[b] = o_valid[b] && i_ready[b].
  - Pop without a load: o_valid[b] goes to 0 and the branch data slice clears to 0 (dummy data is all zeros).
  - Pop and load in the same cycle: the slot takes the new data and stays FULL (no bubble).
- Stall: while o_valid[b]=1 and i_ready[b]=0, the branch data and valid hold stable.
- i_en=0: o_ready=0 and no loads occur, but FULL slots still drain via i_ready. i_cmd and i_data_bus are don't-care.
- Drop (cmd 00, i_en=1, i_valid=1): the input is consumed in 1 cycle and neither branch changes. This is not an error.
- Non-targeted branch: unaffected by fire_in and may pop independently in the same cycle.
- Combinational paths: i_ready, i_en, i_cmd and rst to o_ready. There is no combinational path from i_valid or i_data_bus to any output.

Test Plan:
- Reset: rst=1 for 2 cycles with i_valid=1, i_en=1, i_cmd=11, i_ready=11 -> o_valid=00, o_data_bus=0, o_ready=0. After release, o_ready=1.
- Unicast low then high: i_ready=11, i_en=1.
  - Cycle 0: i_cmd=01, data 32'hAAAAAAAA. Cycle 1: i_cmd=10, data 32'hFFFFFFFF.
  - Expect cycle 1: o_valid=01, low=32'hAAAAAAAA.
  - Expect cycle 2: o_valid=10, high=32'hFFFFFFFF, low=0.
- Multicast with backpressure:
  - Cycle 0: i_cmd=11, data 32'h12345678, i_ready=11.
  - Cycle 1: o_valid=11, both slices = 32'h12345678. Hold i_ready=01 with a new i_cmd=11, data 32'h0.
  - Expect: o_ready=0 while the high slot is stalled; the high slice holds 32'h12345678; no partial load into the low slot.
- Disable and drop:
  - i_en=0, i_valid=1, i_cmd=01 -> o_ready=0, o_valid stays 00.
  - Then i_en=1, i_cmd=00 -> o_ready=1, input consumed, o_valid stays 00.
- Streaming and simultaneous pop/load: i_cmd=01, i_ready=01, data incrementing 1,2,3,4 on back-to-back cycles -> low branch shows 1,2,3,4 on consecutive cycles, o_valid[0]=1 throughout, o_ready=1 every cycle.
- Reset mid-operation: with both slots FULL and i_ready=00, assert rst for 1 cycle -> next cycle o_valid=00, o_data_bus=0, o_ready=1 (i_en=1, i_cmd=11).
